// File: rtl/data_mem_responder_if.sv
// Request/response bus between a processor load/store unit and the data memory responder.
// A request transfers on a rising edge where req_valid && req_ready; resp_valid is a single-cycle pulse with no back-pressure.
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-port word memory answering RV32I byte/halfword/word loads and stores, one request at a time.
// Sub-word stores are read-modify-write; misaligned, out-of-range or illegal-size requests answer with resp_err.
module data_mem_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic                 clock,
    input  logic                 reset,
    data_mem_responder_if.slave  bus,
    output logic [1:0]           dbgState
);
    localparam int          IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) * 33'd4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t state;
    state_t nextState;

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdWord;

    logic             weQ;
    logic [2:0]       funct3Q;
    logic [1:0]       addrLowQ;
    logic [31:0]      wdataQ;
    logic [IDX_W-1:0] idxQ;

    logic             accept;
    logic [31:0]      reqOffset;
    logic             inRange;
    logic             sizeErr;
    logic             reqErr;
    logic [IDX_W-1:0] reqIdx;

    logic [7:0]  byteSel;
    logic [15:0] halfSel;
    logic [31:0] loadData;
    logic [31:0] mergedWord;

    logic        respValid;
    logic        respErr;
    logic [31:0] respRdata;

    assign accept = bus.req_valid && bus.req_ready;

    // The full offset is compared, so an address one past the top never folds back onto word 0.
    assign reqOffset = bus.req_addr - BASE_ADDR;
    assign inRange   = (bus.req_addr >= BASE_ADDR) && ({1'b0, reqOffset} < SPAN);
    assign reqIdx    = reqOffset[IDX_W+1:2];

    always_comb begin
        sizeErr = 1'b1;
        case (bus.req_funct3)
            F3_B:    sizeErr = 1'b0;
            F3_H:    sizeErr = bus.req_addr[0];
            F3_W:    sizeErr = (bus.req_addr[1:0] != 2'b00);
            F3_BU:   sizeErr = bus.req_we;
            F3_HU:   sizeErr = bus.req_we || bus.req_addr[0];
            default: sizeErr = 1'b1;
        endcase
    end

    assign reqErr = !inRange || sizeErr;

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (reqErr)
                        nextState = RESP;
                    else if (bus.req_we && bus.req_funct3 == F3_W)
                        nextState = WR;
                    else
                        nextState = RD;
                end
            end
            RD:      nextState = weQ ? WR : RESP;
            WR:      nextState = RESP;
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_ff @(posedge clock) begin
        if (!reset && accept) begin
            weQ      <= bus.req_we;
            funct3Q  <= bus.req_funct3;
            addrLowQ <= bus.req_addr[1:0];
            wdataQ   <= bus.req_wdata;
            idxQ     <= reqIdx;
        end
    end

    // The read is launched on the accept edge so the word is already in rdWord during RD.
    always_ff @(posedge clock) begin
        if (!reset && state == WR)
            mem[idxQ] <= mergedWord;
        if (!reset && accept && !reqErr)
            rdWord <= mem[reqIdx];
    end

    assign byteSel = rdWord[{addrLowQ, 3'b000} +: 8];
    assign halfSel = addrLowQ[1] ? rdWord[31:16] : rdWord[15:0];

    always_comb begin
        loadData = rdWord;
        case (funct3Q)
            F3_B:    loadData = {{24{byteSel[7]}}, byteSel};
            F3_BU:   loadData = {24'h000000, byteSel};
            F3_H:    loadData = {{16{halfSel[15]}}, halfSel};
            F3_HU:   loadData = {16'h0000, halfSel};
            default: loadData = rdWord;
        endcase
    end

    always_comb begin
        mergedWord = rdWord;
        case (funct3Q)
            F3_B: mergedWord[{addrLowQ, 3'b000} +: 8] = wdataQ[7:0];
            F3_H: begin
                if (addrLowQ[1])
                    mergedWord[31:16] = wdataQ[15:0];
                else
                    mergedWord[15:0] = wdataQ[15:0];
            end
            default: mergedWord = wdataQ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            respValid <= 1'b0;
            respErr   <= 1'b0;
            respRdata <= 32'h0;
        end else begin
            respValid <= (nextState == RESP);
            respErr   <= (state == IDLE) && accept && reqErr;
            respRdata <= (state == RD && !weQ) ? loadData : 32'h0;
        end
    end

    assign bus.req_ready  = (state == IDLE);
    assign bus.resp_valid = respValid;
    assign bus.resp_err   = respErr;
    assign bus.resp_rdata = respRdata;
    assign dbgState       = state;
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: word/byte/halfword access, errors, handshake and reset abort.
module tb_data_mem_responder;
    logic       clock;
    logic       reset;
    logic [1:0] dbgState;
    int         nCompared;
    int         nMismatched;

    data_mem_responder_if bus();

    data_mem_responder #(
        .BASE_ADDR  (32'h1001_0000),
        .DEPTH_WORDS(1024)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .dbgState(dbgState)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    function automatic vec_t mkVec(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                   input logic [31:0] wdata, input int lat, input logic [31:0] rdata,
                                   input logic err);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.lat = lat; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    // Drives one request, then reports the response latency in cycles after the accept edge (0 = none).
    task automatic runReq(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat, output logic [31:0] rd,
                          output logic err, output logic rdy);
        @(negedge clock);
        rdy            = bus.req_ready;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clock);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = $urandom_range(0, 1);
        bus.req_funct3 = 3'($urandom_range(0, 7));
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
        lat = 0;
        rd  = 32'h0;
        err = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clock);
            if (bus.resp_valid) begin
                lat = n;
                rd  = bus.resp_rdata;
                err = bus.resp_err;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        nCompared++;
        if (bus.req_ready !== 1'b1) begin
            nMismatched++; $display("FAIL reset_ready got %b want 1", bus.req_ready);
        end
        nCompared++;
        if ({bus.resp_valid, bus.resp_err, bus.resp_rdata} !== 34'h0) begin
            nMismatched++;
            $display("FAIL reset_resp got v=%b e=%b d=%h want all 0", bus.resp_valid, bus.resp_err, bus.resp_rdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_word;
        vec_t v[2];
        int lat; logic [31:0] rd; logic err; logic rdy;
        v[0] = mkVec(1'b1, 3'b010, 32'h1001_0004, 32'hDEAD_BEEF, 2, 32'h0, 1'b0);
        v[1] = mkVec(1'b0, 3'b010, 32'h1001_0004, 32'h0,         2, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < 2; i++) begin
            runReq(v[i].we, v[i].f3, v[i].addr, v[i].wdata, lat, rd, err, rdy);
            nCompared++;
            if (rdy !== 1'b1) begin nMismatched++; $display("FAIL word_ready[%0d] got %b want 1", i, rdy); end
            nCompared++;
            if (lat !== v[i].lat) begin nMismatched++; $display("FAIL word_latency[%0d] got %0d want %0d", i, lat, v[i].lat); end
            nCompared++;
            if (rd !== v[i].rdata) begin nMismatched++; $display("FAIL word_rdata[%0d] got %h want %h", i, rd, v[i].rdata); end
            nCompared++;
            if (err !== v[i].err) begin nMismatched++; $display("FAIL word_err[%0d] got %b want %b", i, err, v[i].err); end
        end
    endtask

    task automatic test_byte_rmw;
        vec_t v[4];
        int lat; logic [31:0] rd; logic err; logic rdy;
        v[0] = mkVec(1'b1, 3'b000, 32'h1001_0005, 32'h0000_0080, 3, 32'h0, 1'b0);
        v[1] = mkVec(1'b0, 3'b010, 32'h1001_0004, 32'h0, 2, 32'hDEAD_80EF, 1'b0);
        v[2] = mkVec(1'b0, 3'b000, 32'h1001_0005, 32'h0, 2, 32'hFFFF_FF80, 1'b0);
        v[3] = mkVec(1'b0, 3'b100, 32'h1001_0005, 32'h0, 2, 32'h0000_0080, 1'b0);
        for (int i = 0; i < 4; i++) begin
            runReq(v[i].we, v[i].f3, v[i].addr, v[i].wdata, lat, rd, err, rdy);
            nCompared++;
            if (lat !== v[i].lat) begin nMismatched++; $display("FAIL byte_latency[%0d] got %0d want %0d", i, lat, v[i].lat); end
            nCompared++;
            if (rd !== v[i].rdata) begin nMismatched++; $display("FAIL byte_rdata[%0d] got %h want %h", i, rd, v[i].rdata); end
            nCompared++;
            if (err !== v[i].err) begin nMismatched++; $display("FAIL byte_err[%0d] got %b want %b", i, err, v[i].err); end
        end
    endtask

    task automatic test_halfword;
        vec_t v[5];
        int lat; logic [31:0] rd; logic err; logic rdy;
        v[0] = mkVec(1'b1, 3'b001, 32'h1001_0006, 32'hFFFF_1234, 3, 32'h0, 1'b0);
        v[1] = mkVec(1'b0, 3'b001, 32'h1001_0006, 32'h0, 2, 32'h0000_1234, 1'b0);
        v[2] = mkVec(1'b0, 3'b101, 32'h1001_0004, 32'h0, 2, 32'h0000_80EF, 1'b0);
        v[3] = mkVec(1'b0, 3'b001, 32'h1001_0004, 32'h0, 2, 32'hFFFF_80EF, 1'b0);
        v[4] = mkVec(1'b0, 3'b010, 32'h1001_0004, 32'h0, 2, 32'h1234_80EF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            runReq(v[i].we, v[i].f3, v[i].addr, v[i].wdata, lat, rd, err, rdy);
            nCompared++;
            if (lat !== v[i].lat) begin nMismatched++; $display("FAIL half_latency[%0d] got %0d want %0d", i, lat, v[i].lat); end
            nCompared++;
            if (rd !== v[i].rdata) begin nMismatched++; $display("FAIL half_rdata[%0d] got %h want %h", i, rd, v[i].rdata); end
            nCompared++;
            if (err !== v[i].err) begin nMismatched++; $display("FAIL half_err[%0d] got %b want %b", i, err, v[i].err); end
        end
    endtask

    task automatic test_errors;
        vec_t v[8];
        int lat; logic [31:0] rd; logic err; logic rdy;
        v[0] = mkVec(1'b0, 3'b010, 32'h1001_0002, 32'h0, 1, 32'h0, 1'b1);
        v[1] = mkVec(1'b0, 3'b001, 32'h1001_0001, 32'h0, 1, 32'h0, 1'b1);
        v[2] = mkVec(1'b0, 3'b010, 32'h1000_FFFC, 32'h0, 1, 32'h0, 1'b1);
        v[3] = mkVec(1'b0, 3'b010, 32'h1001_1000, 32'h0, 1, 32'h0, 1'b1);
        v[4] = mkVec(1'b1, 3'b100, 32'h1001_0004, 32'h0000_00FF, 1, 32'h0, 1'b1);
        v[5] = mkVec(1'b0, 3'b011, 32'h1001_0004, 32'h0, 1, 32'h0, 1'b1);
        v[6] = mkVec(1'b1, 3'b010, 32'h1001_0006, 32'h5555_5555, 1, 32'h0, 1'b1);
        v[7] = mkVec(1'b0, 3'b010, 32'h1001_0004, 32'h0, 2, 32'h1234_80EF, 1'b0);
        for (int i = 0; i < 8; i++) begin
            runReq(v[i].we, v[i].f3, v[i].addr, v[i].wdata, lat, rd, err, rdy);
            nCompared++;
            if (lat !== v[i].lat) begin nMismatched++; $display("FAIL err_latency[%0d] got %0d want %0d", i, lat, v[i].lat); end
            nCompared++;
            if (rd !== v[i].rdata) begin nMismatched++; $display("FAIL err_rdata[%0d] got %h want %h", i, rd, v[i].rdata); end
            nCompared++;
            if (err !== v[i].err) begin nMismatched++; $display("FAIL err_flag[%0d] got %b want %b", i, err, v[i].err); end
        end
    endtask

    task automatic test_boundary;
        vec_t v[6];
        int lat; logic [31:0] rd; logic err; logic rdy;
        v[0] = mkVec(1'b1, 3'b010, 32'h1001_0000, 32'h1122_3344, 2, 32'h0, 1'b0);
        v[1] = mkVec(1'b1, 3'b010, 32'h1001_0FFC, 32'hCAFE_F00D, 2, 32'h0, 1'b0);
        v[2] = mkVec(1'b1, 3'b010, 32'h1001_1000, 32'h5555_5555, 1, 32'h0, 1'b1);
        v[3] = mkVec(1'b0, 3'b010, 32'h1001_0FFC, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
        v[4] = mkVec(1'b0, 3'b100, 32'h1001_0FFF, 32'h0, 2, 32'h0000_00CA, 1'b0);
        v[5] = mkVec(1'b0, 3'b010, 32'h1001_0000, 32'h0, 2, 32'h1122_3344, 1'b0);
        for (int i = 0; i < 6; i++) begin
            runReq(v[i].we, v[i].f3, v[i].addr, v[i].wdata, lat, rd, err, rdy);
            nCompared++;
            if (lat !== v[i].lat) begin nMismatched++; $display("FAIL edge_latency[%0d] got %0d want %0d", i, lat, v[i].lat); end
            nCompared++;
            if (rd !== v[i].rdata) begin nMismatched++; $display("FAIL edge_rdata[%0d] got %h want %h", i, rd, v[i].rdata); end
            nCompared++;
            if (err !== v[i].err) begin nMismatched++; $display("FAIL edge_err[%0d] got %b want %b", i, err, v[i].err); end
        end
    endtask

    // req_valid stays high across three loads; each load is IDLE, RD, RESP at successive samples.
    task automatic test_back_to_back;
        int  nResp;
        logic expReady;
        logic expResp;
        nResp = 0;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h1001_0004;
        bus.req_wdata  = 32'h0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clock);
            expReady = (k % 3 == 0);
            expResp  = (k % 3 == 2);
            nCompared++;
            if (bus.req_ready !== expReady) begin
                nMismatched++; $display("FAIL b2b_ready[%0d] got %b want %b", k, bus.req_ready, expReady);
            end
            nCompared++;
            if (bus.resp_valid !== expResp) begin
                nMismatched++; $display("FAIL b2b_resp_valid[%0d] got %b want %b", k, bus.resp_valid, expResp);
            end
            if (bus.resp_valid === 1'b1) begin
                nResp++;
                nCompared++;
                if (bus.resp_rdata !== 32'h1234_80EF) begin
                    nMismatched++; $display("FAIL b2b_rdata[%0d] got %h want 123480ef", k, bus.resp_rdata);
                end
            end
            if (k == 9) bus.req_valid = 1'b0;
        end
        nCompared++;
        if (nResp !== 3) begin nMismatched++; $display("FAIL b2b_count got %0d want 3", nResp); end
    endtask

    task automatic test_reset_midop;
        logic sawResp;
        int lat; logic [31:0] rd; logic err; logic rdy;
        @(negedge clock);
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h1001_0004;
        bus.req_wdata  = 32'h0000_00AA;
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        nCompared++;
        if (dbgState !== 2'd2) begin nMismatched++; $display("FAIL midop_state got %0d want 2", dbgState); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        sawResp = bus.resp_valid;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            if (bus.resp_valid === 1'b1) sawResp = 1'b1;
        end
        nCompared++;
        if (sawResp !== 1'b0) begin nMismatched++; $display("FAIL midop_no_resp got %b want 0", sawResp); end
        runReq(1'b0, 3'b010, 32'h1001_0004, 32'h0, lat, rd, err, rdy);
        nCompared++;
        if (rdy !== 1'b1) begin nMismatched++; $display("FAIL midop_ready got %b want 1", rdy); end
        nCompared++;
        if (lat !== 2) begin nMismatched++; $display("FAIL midop_latency got %0d want 2", lat); end
        nCompared++;
        if (rd !== 32'h1234_80EF) begin nMismatched++; $display("FAIL midop_rdata got %h want 123480ef", rd); end
    endtask

    initial begin
        nCompared      = 0;
        nMismatched    = 0;
        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        test_reset();
        test_word();
        test_byte_rmw();
        test_halfword();
        test_errors();
        test_boundary();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
